// File: rtl/io_input_conditioner.sv
// Two-flop synchroniser plus per-bit debounce for slide switches and active-low keys,
// with registered change/press pulses. Define IO_KEY_PRESS_LATCH_EN to add sticky key_pending flags.
module io_input_conditioner #(
    parameter int N_SW            = 10,
    parameter int N_KEY           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_KEY-1:0] key_raw,
`ifdef IO_KEY_PRESS_LATCH_EN
    input  logic [N_KEY-1:0] key_clr,
    output logic [N_KEY-1:0] key_pending,
`endif
    output logic [N_SW-1:0]  sw_out,
    output logic [N_KEY-1:0] key_out,
    output logic             sw_changed,
    output logic [N_KEY-1:0] key_press
);

    localparam int N = N_SW + N_KEY;
    // Keys are active-low, so they idle (and reset) high; switches reset low.
    localparam logic [N-1:0]         RST_VAL = {{N_KEY{1'b1}}, {N_SW{1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]         raw;
    logic [N-1:0]         s1_q, s2_q;
    logic [N-1:0]         out_q, out_d;
    logic [N-1:0]         upd;
    logic [CNT_WIDTH-1:0] cnt_q [N];
    logic [CNT_WIDTH-1:0] cnt_d [N];
    logic                 sw_changed_q, sw_changed_d;
    logic [N_KEY-1:0]     key_press_q, key_press_d;

    assign raw = {key_raw, sw_raw};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        out_d = out_q;
        upd   = '0;
        for (int b = 0; b < N; b++) begin
            cnt_d[b] = '0;
            if (s2_q[b] != out_q[b]) begin
                if (cnt_q[b] == CNT_MAX) begin
                    out_d[b] = s2_q[b];
                    upd[b]   = 1'b1;
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_WIDTH'(1);
                end
            end
        end
        sw_changed_d = |upd[N_SW-1:0];
        key_press_d  = upd[N-1:N_SW] & ~out_d[N-1:N_SW];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q         <= RST_VAL;
            s2_q         <= RST_VAL;
            out_q        <= RST_VAL;
            sw_changed_q <= 1'b0;
            key_press_q  <= '0;
            // NOTE: the counter array is small flop storage, not RAM, so it is reset like any other state.
            for (int b = 0; b < N; b++) cnt_q[b] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep s1 -> s2 a true two-stage chain.
            s1_q         <= raw;
            s2_q         <= s1_q;
            out_q        <= out_d;
            sw_changed_q <= sw_changed_d;
            key_press_q  <= key_press_d;
            for (int b = 0; b < N; b++) cnt_q[b] <= cnt_d[b];
        end
    end

    assign sw_out     = out_q[N_SW-1:0];
    assign key_out    = out_q[N-1:N_SW];
    assign sw_changed = sw_changed_q;
    assign key_press  = key_press_q;

`ifdef IO_KEY_PRESS_LATCH_EN
    logic [N_KEY-1:0] key_pending_q;

    // Set wins over clear when a press lands on the same edge as key_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) key_pending_q <= '0;
        else       key_pending_q <= (key_pending_q & ~key_clr) | key_press_d;
    end

    assign key_pending = key_pending_q;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES=4: vector table plus
// hand-written bounce, async-reset and (when IO_KEY_PRESS_LATCH_EN is defined) pending-flag sequences.
module tb_io_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] sw_raw;
    logic [3:0] key_raw;
    logic [9:0] sw_out;
    logic [3:0] key_out;
    logic       sw_changed;
    logic [3:0] key_press;
`ifdef IO_KEY_PRESS_LATCH_EN
    logic [3:0] key_clr;
    logic [3:0] key_pending;
`endif

    int checks = 0;
    int errors = 0;

    io_input_conditioner #(
        .N_SW(10), .N_KEY(4), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .key_raw    (key_raw),
`ifdef IO_KEY_PRESS_LATCH_EN
        .key_clr    (key_clr),
        .key_pending(key_pending),
`endif
        .sw_out     (sw_out),
        .key_out    (key_out),
        .sw_changed (sw_changed),
        .key_press  (key_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [9:0] sw;
        logic [3:0] key;
        logic [9:0] e_sw;
        logic [3:0] e_key;
        logic       e_chg;
        logic [3:0] e_press;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [9:0] sw, input logic [3:0] key,
                       input logic [9:0] e_sw, input logic [3:0] e_key,
                       input logic e_chg, input logic [3:0] e_press);
        vec_t v;
        v.rst = rst; v.sw = sw; v.key = key;
        v.e_sw = e_sw; v.e_key = e_key; v.e_chg = e_chg; v.e_press = e_press;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        sw_raw  = 10'h3FF;
        key_raw = 4'h0;
`ifdef IO_KEY_PRESS_LATCH_EN
        key_clr = 4'h0;
`endif

        // Reset with all inputs active, then release and let them through (edge 6).
        for (int i = 0; i < 2; i++) add(1'b1, 10'h3FF, 4'h0, 10'h000, 4'hF, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) add(1'b0, 10'h3FF, 4'h0, 10'h000, 4'hF, 1'b0, 4'h0);
        add(1'b0, 10'h3FF, 4'h0, 10'h3FF, 4'h0, 1'b1, 4'hF);
        add(1'b0, 10'h3FF, 4'h0, 10'h3FF, 4'h0, 1'b0, 4'h0);
        // Key 0 release: rises at edge 6, no press pulse.
        for (int i = 0; i < 5; i++) add(1'b0, 10'h3FF, 4'h1, 10'h3FF, 4'h0, 1'b0, 4'h0);
        for (int i = 0; i < 2; i++) add(1'b0, 10'h3FF, 4'h1, 10'h3FF, 4'h1, 1'b0, 4'h0);
        // Fresh reset at idle levels, then clean switch change to 0x005.
        for (int i = 0; i < 2; i++) add(1'b1, 10'h000, 4'hF, 10'h000, 4'hF, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) add(1'b0, 10'h005, 4'hF, 10'h000, 4'hF, 1'b0, 4'h0);
        add(1'b0, 10'h005, 4'hF, 10'h005, 4'hF, 1'b1, 4'h0);
        add(1'b0, 10'h005, 4'hF, 10'h005, 4'hF, 1'b0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            sw_raw  = vecs[i].sw;
            key_raw = vecs[i].key;
            step();
            check($sformatf("vec%0d sw_out", i),     32'(sw_out),     32'(vecs[i].e_sw));
            check($sformatf("vec%0d key_out", i),    32'(key_out),    32'(vecs[i].e_key));
            check($sformatf("vec%0d sw_changed", i), 32'(sw_changed), 32'(vecs[i].e_chg));
            check($sformatf("vec%0d key_press", i),  32'(key_press),  32'(vecs[i].e_press));
        end

        // Bounce on key 2: 2-cycle levels never survive the 4-cycle window.
        for (int i = 0; i < 12; i++) begin
            key_raw[2] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            check($sformatf("bounce%0d key_out", i),   32'(key_out),   32'h0000_000F);
            check($sformatf("bounce%0d key_press", i), 32'(key_press), 32'h0);
        end
        key_raw[2] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("settle%0d key_out", i), 32'(key_out), 32'h0000_000F);
        end
        step();
        check("bounce fall key_out",   32'(key_out),   32'h0000_000B);
        check("bounce fall key_press", 32'(key_press), 32'h0000_0004);
        step();
        check("bounce press one cycle", 32'(key_press), 32'h0);

        // Key 1 pressed for 3 edges, then async reset pulse between edges.
        key_raw = 4'b1001;
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        check("async reset key_out",    32'(key_out),    32'h0000_000F);
        check("async reset sw_out",     32'(sw_out),     32'h0);
        check("async reset key_press",  32'(key_press),  32'h0);
        check("async reset sw_changed", 32'(sw_changed), 32'h0);
        #1 reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("post-reset%0d key_out", i), 32'(key_out),   32'h0000_000F);
            check($sformatf("post-reset%0d press", i),   32'(key_press), 32'h0);
        end
        step();
        check("post-reset key_out",    32'(key_out),    32'h0000_0009);
        check("post-reset key_press",  32'(key_press),  32'h0000_0006);
        check("post-reset sw_out",     32'(sw_out),     32'h0000_0005);
        check("post-reset sw_changed", 32'(sw_changed), 32'h1);
        step();
        check("post-reset pulses clear", 32'({sw_changed, key_press}), 32'h0);

`ifdef IO_KEY_PRESS_LATCH_EN
        key_clr = 4'hF;
        step();
        key_clr = 4'h0;
        check("pending cleared", 32'(key_pending), 32'h0);
        key_raw = 4'b0001;
        repeat (5) step();
        check("pending before press", 32'(key_pending), 32'h0);
        step();
        check("press3 key_out", 32'(key_out),     32'h0000_0001);
        check("press3 pending", 32'(key_pending), 32'h0000_0008);
        repeat (3) step();
        check("pending holds", 32'(key_pending), 32'h0000_0008);
        key_clr = 4'b1000;
        step();
        key_clr = 4'h0;
        check("pending clr", 32'(key_pending), 32'h0);
        key_raw = 4'b1001;
        repeat (6) step();
        check("release3 key_out", 32'(key_out), 32'h0000_0009);
        key_raw = 4'b0001;
        repeat (5) step();
        key_clr = 4'b1000;
        step();
        key_clr = 4'h0;
        check("set-vs-clr press",   32'(key_press),   32'h0000_0008);
        check("set-vs-clr pending", 32'(key_pending), 32'h0000_0008);
        step();
        check("set-vs-clr holds", 32'(key_pending), 32'h0000_0008);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Conditions raw board inputs (slide switches, active-low push-buttons) before they reach the data-memory MMIO read path.
- Synchronises each input to clk, debounces it per bit, and presents clean levels on sw_out/key_out.
- sw_out/key_out feed the data memory's sw/key inputs directly. key_out keeps the raw active-low polarity, because the memory stage inverts keys itself.
- Also produces one-cycle event pulses for debug/interrupt use.

Parameters:
- N_SW, 10, number of switch inputs.
- N_KEY, 4, number of key inputs.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before an output changes (10 ms at 50 MHz). Must be >= 1.
- CNT_WIDTH, 20, width of each per-bit stability counter. Must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sw_raw  input  N_SW  raw switch pins, asynchronous to clk
- key_raw  input  N_KEY  raw key pins, asynchronous, active-low (0 = pressed)
- sw_out  output  N_SW  debounced switch levels, to data memory sw
- key_out  output  N_KEY  debounced key levels, active-low, to data memory key
- sw_changed  output  1  one-cycle pulse when any sw_out bit changes
- key_press  output  N_KEY  one-cycle pulse per key on debounced press (key_out bit 1->0)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high; all flops reset on posedge reset, independent of clk.
- Reset values:
  - sw_out = 0, key_out = all 1s (released).
  - sw_changed = 0, key_press = 0.
  - Sync stage 1 and stage 2 reset to the same values as their outputs (switches 0, keys 1).
  - All counters 0.
  - Reset asserted mid-count discards partial counts; no pulse is generated by reset or by its release.
- Synchroniser: two-flop chain per bit (s1 <= raw, s2 <= s1). Only s2 is used downstream.
- Debounce: independent per bit, for every switch and key bit b, at each posedge clk:
  - If s2[b] == out[b]: cnt[b] <= 0.
  - Else if cnt[b] == DEBOUNCE_CYCLES-1: out[b] <= s2[b], cnt[b] <= 0.
  - Else: cnt[b] <= cnt[b]+1.
- Latency:
  - A raw change held stable appears on the output at the (DEBOUNCE_CYCLES+2)th posedge after the raw edge (2 sync + DEBOUNCE_CYCLES compare cycles).
  - Minimum latency is 3 edges when DEBOUNCE_CYCLES = 1.
- Glitch rejection: any return of s2[b] to out[b] before the count completes clears cnt[b]. Mismatches shorter than DEBOUNCE_CYCLES cycles (as seen at s2) never reach the output.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap. The counter saturating path is the update path.
- Pulses (registered, asserted in the same cycle the output changes, high exactly 1 cycle):
  - sw_changed = OR over bits of (sw_out bit updates this edge).
  - key_press[i] = key_out[i] updates 1->0 this edge.
  - Key release (0->1) produces no pulse.
- Simultaneous events:
  - Several bits may update on the same edge. sw_changed is still a single 1-cycle pulse, and several key_press bits may assert together.
  - A bit that updates on consecutive debounce windows yields separate pulses.
- No combinational path from any input to any output.

Optional Feature:
- Macro: IO_KEY_PRESS_LATCH_EN.
- Defined:
  - Adds input key_clr [N_KEY] and output key_pending [N_KEY], reset 0.
  - key_pending[i] is set on key_press[i] and cleared when key_clr[i] is high at a posedge.
  - Set wins over clear on the same edge.
  - key_pending feeds an MMIO status read so software does not miss short presses.
- Undefined: neither port exists, and there is no extra logic.

Test Plan:
- Reset values: DEBOUNCE_CYCLES=4; assert reset with sw_raw=10'h3FF, key_raw=4'h0, release reset -> sw_out=0, key_out=4'hF, no pulses. Holding the inputs then changes sw_out=10'h3FF and key_out=4'h0 at edge 6 after release, with sw_changed=1 and key_press=4'hF for exactly that cycle.
- Clean switch change: DEBOUNCE_CYCLES=4; sw_raw 0 -> 10'h005 and hold -> sw_out=10'h005 at edge 6, sw_changed pulse 1 cycle, no change at edges 1-5.
- Bounce rejection: key_raw[2] toggles 1->0->1->0 every 2 cycles for 12 cycles, then holds 0 -> key_out[2] stays 1 during bouncing, falls 6 edges after the final stable 0, key_press=4'b0100 once.
- Key release: key_raw[0] 0->1 held -> key_out[0] rises at edge 6, key_press stays 0.
- Async reset mid-count: key_raw[1] low for 3 edges, then pulse reset between clock edges -> key_out returns to 4'hF immediately. The count restarts, so key_out[1] falls at edge 6 after reset release.
- IO_KEY_PRESS_LATCH_EN defined: press key 3 -> key_pending=4'b1000 and it holds. key_clr[3]=1 for one edge -> 0. A press coinciding with key_clr leaves key_pending[3]=1.
